// File: rtl/region_mapper_pkg.sv
// region_mapper_pkg: field selects, flag positions, region entry and commit FSM types for region_mapper
package region_mapper_pkg;
  localparam int RM_ADDR_MAX = 32;
  localparam logic [2:0] FLD_MVAL  = 3'd0;
  localparam logic [2:0] FLD_MMASK = 3'd1;
  localparam logic [2:0] FLD_XBASE = 3'd2;
  localparam logic [2:0] FLD_XMASK = 3'd3;
  localparam logic [2:0] FLD_FLAGS = 3'd4;
  localparam int FLG_ROM      = 0;
  localparam int FLG_SAVERAM  = 1;
  localparam int FLG_WRITABLE = 2;
  localparam int FLG_ENABLE   = 3;
  typedef struct packed {
    logic [RM_ADDR_MAX-1:0] mval;
    logic [RM_ADDR_MAX-1:0] mmask;
    logic [RM_ADDR_MAX-1:0] xbase;
    logic [RM_ADDR_MAX-1:0] xmask;
    logic [3:0]             flags;
  } region_entry_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_COPY} commit_state_t;
  function automatic logic region_hit(input logic en, input logic [RM_ADDR_MAX-1:0] a, val, mask);
    return en && (((a ^ val) & mask) == '0);
  endfunction
endpackage

// File: rtl/region_mapper_prio_enc.sv
// region_prio_enc: lowest-index priority encoder over the region match vector
module region_prio_enc #(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  // scan from the top down so the lowest set bit is the final assignment
  always_comb begin
    o_idx = '0;
    for (int k = N - 1; k >= 0; k--) o_idx = i_vec[k] ? IDX_W'(k) : o_idx;
  end
  assign o_any = |i_vec;
endmodule

// File: rtl/region_mapper.sv
// region_mapper: 2-stage SNES-to-ROM address region lookup with shadow/active tables; optional hit counters via REGION_MAPPER_HITCNT_EN (ADDR_W up to 32)
module region_mapper
  import region_mapper_pkg::*;
#(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_W      = 24,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(NUM_REGIONS)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic              snes_addr_valid,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [2:0]        cfg_field,
  input  logic [ADDR_W-1:0] cfg_data,
  input  logic              cfg_commit,
  output logic              cfg_busy,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_hit,
  output logic              is_rom,
  output logic              is_saveram,
  output logic              is_writable,
  output logic [IDX_W-1:0]  region,
  output logic              out_valid
`ifdef REGION_MAPPER_HITCNT_EN
  ,
  input  logic [IDX_W-1:0]  hit_cnt_idx,
  output logic [CNT_W-1:0]  hit_cnt
`endif
);
  region_entry_t          r_shd [NUM_REGIONS];
  region_entry_t          r_act [NUM_REGIONS];
  commit_state_t          r_state;
  logic                   r_v1;
  logic [NUM_REGIONS-1:0] r_match1;
  logic [ADDR_W-1:0]      r_addr1;
  logic [NUM_REGIONS-1:0] w_match;
  logic [RM_ADDR_MAX-1:0] w_addr;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_any;

  assign w_addr   = RM_ADDR_MAX'(snes_addr);
  assign cfg_busy = r_state != ST_IDLE;

  // shadow table: configuration writes land here only
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int k = 0; k < NUM_REGIONS; k++) r_shd[k] <= '0;
    end else if (cfg_we) begin
      case (cfg_field)
        FLD_MVAL:  r_shd[cfg_idx].mval  <= RM_ADDR_MAX'(cfg_data);
        FLD_MMASK: r_shd[cfg_idx].mmask <= RM_ADDR_MAX'(cfg_data);
        FLD_XBASE: r_shd[cfg_idx].xbase <= RM_ADDR_MAX'(cfg_data);
        FLD_XMASK: r_shd[cfg_idx].xmask <= RM_ADDR_MAX'(cfg_data);
        FLD_FLAGS: r_shd[cfg_idx].flags <= cfg_data[3:0];
        default: ;
      endcase
    end
  end

  // commit FSM: wait for an empty pipeline, then copy shadow to active in COPY
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      for (int k = 0; k < NUM_REGIONS; k++) r_act[k] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= cfg_commit ? ST_PEND : ST_IDLE;
        ST_PEND: r_state <= (!snes_addr_valid && !r_v1 && !out_valid) ? ST_COPY : ST_PEND;
        ST_COPY: begin
          r_act   <= r_shd;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // a lookup entering during COPY matches against the table that stage 2 will see
  always_comb begin
    w_match = '0;
    for (int k = 0; k < NUM_REGIONS; k++)
      w_match[k] = r_state == ST_COPY
        ? region_hit(r_shd[k].flags[FLG_ENABLE], w_addr, r_shd[k].mval, r_shd[k].mmask)
        : region_hit(r_act[k].flags[FLG_ENABLE], w_addr, r_act[k].mval, r_act[k].mmask);
  end

  // stage 1: register match vector and address
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_v1     <= 1'b0;
      r_match1 <= '0;
      r_addr1  <= '0;
    end else begin
      r_v1     <= snes_addr_valid;
      r_match1 <= w_match;
      r_addr1  <= snes_addr;
    end
  end

  region_prio_enc #(.N(NUM_REGIONS)) u_prio (
    .i_vec (r_match1),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // stage 2: translate through the winning region; outputs hold when no lookup completes
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid   <= 1'b0;
      rom_addr    <= '0;
      rom_hit     <= 1'b0;
      is_rom      <= 1'b0;
      is_saveram  <= 1'b0;
      is_writable <= 1'b0;
      region      <= '0;
    end else begin
      out_valid <= r_v1;
      if (r_v1) begin
        rom_addr    <= w_any ? ADDR_W'(r_act[w_idx].xbase | (RM_ADDR_MAX'(r_addr1) & r_act[w_idx].xmask)) : '0;
        rom_hit     <= w_any;
        is_rom      <= w_any && r_act[w_idx].flags[FLG_ROM];
        is_saveram  <= w_any && r_act[w_idx].flags[FLG_SAVERAM];
        is_writable <= w_any && r_act[w_idx].flags[FLG_WRITABLE];
        region      <= w_any ? w_idx : '0;
      end
    end
  end

`ifdef REGION_MAPPER_HITCNT_EN
  logic [CNT_W-1:0] r_cnt [NUM_REGIONS];

  // saturating per-region hit counters, cleared whenever a new table goes live
  always_ff @(posedge CLK) begin
    if (!RST_N || r_state == ST_COPY) begin
      for (int k = 0; k < NUM_REGIONS; k++) r_cnt[k] <= '0;
    end else if (r_v1 && w_any && r_cnt[w_idx] != '1) begin
      r_cnt[w_idx] <= r_cnt[w_idx] + 1'b1;
    end
  end

  assign hit_cnt = r_cnt[hit_cnt_idx];
`endif
endmodule

// File: tb/tb_region_mapper.sv
// tb_region_mapper: directed self-checking bench for region_mapper
module tb_region_mapper;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic [23:0] snes_addr;
  logic        snes_addr_valid;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [2:0]  cfg_field;
  logic [23:0] cfg_data;
  logic        cfg_commit;
  logic        cfg_busy;
  logic [23:0] rom_addr;
  logic        rom_hit, is_rom, is_saveram, is_writable;
  logic [2:0]  region;
  logic        out_valid;
`ifdef REGION_MAPPER_HITCNT_EN
  logic [2:0]  hit_cnt_idx;
  logic [15:0] hit_cnt;
`endif
  int n_chk = 0;
  int n_fail = 0;

  region_mapper dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .snes_addr       (snes_addr),
    .snes_addr_valid (snes_addr_valid),
    .cfg_we          (cfg_we),
    .cfg_idx         (cfg_idx),
    .cfg_field       (cfg_field),
    .cfg_data        (cfg_data),
    .cfg_commit      (cfg_commit),
    .cfg_busy        (cfg_busy),
    .rom_addr        (rom_addr),
    .rom_hit         (rom_hit),
    .is_rom          (is_rom),
    .is_saveram      (is_saveram),
    .is_writable     (is_writable),
    .region          (region),
    .out_valid       (out_valid)
`ifdef REGION_MAPPER_HITCNT_EN
    ,
    .hit_cnt_idx     (hit_cnt_idx),
    .hit_cnt         (hit_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic [2:0] fld, input logic [23:0] data);
    cfg_we = 1'b1;
    cfg_idx = idx;
    cfg_field = fld;
    cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic set_region(input logic [2:0] idx, input logic [23:0] mv, mm, xb, xm, input logic [3:0] fl);
    cfg_write(idx, 3'd0, mv);
    cfg_write(idx, 3'd1, mm);
    cfg_write(idx, 3'd2, xb);
    cfg_write(idx, 3'd3, xm);
    cfg_write(idx, 3'd4, {20'd0, fl});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (cfg_busy && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, cfg_busy}, 32'd0);
  endtask

  task automatic commit;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    chk("commit_busy", {31'd0, cfg_busy}, 32'd1);
    wait_idle("commit_done");
  endtask

  // flags expected as {writable, saveram, rom}
  task automatic lookup(input string tag, input logic [23:0] a, input logic hit,
                        input logic [23:0] ra, input logic [2:0] rg, input logic [2:0] fl);
    snes_addr = a;
    snes_addr_valid = 1'b1;
    tick();
    snes_addr_valid = 1'b0;
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_ov"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_hit"}, {31'd0, rom_hit}, {31'd0, hit});
    chk({tag, "_addr"}, {8'd0, rom_addr}, {8'd0, ra});
    chk({tag, "_region"}, {29'd0, region}, {29'd0, rg});
    chk({tag, "_flags"}, {29'd0, is_writable, is_saveram, is_rom}, {29'd0, fl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0;
    snes_addr = '0;
    snes_addr_valid = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_field = '0;
    cfg_data = '0;
    cfg_commit = 1'b0;
`ifdef REGION_MAPPER_HITCNT_EN
    hit_cnt_idx = '0;
`endif
    repeat (3) tick();
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
    chk("rst_addr", {8'd0, rom_addr}, 32'd0);
    chk("rst_hit", {31'd0, rom_hit}, 32'd0);
    RST_N = 1'b1;
    tick();

    set_region(3'd0, 24'h400000, 24'hF00000, 24'hE00000, 24'h01FFFF, 4'hF);
    lookup("shadow_only", 24'h412345, 1'b0, 24'h000000, 3'd0, 3'b000);
    commit();
    lookup("r0", 24'h412345, 1'b1, 24'hE12345, 3'd0, 3'b111);
    tick();
    chk("hold_ov", {31'd0, out_valid}, 32'd0);
    chk("hold_addr", {8'd0, rom_addr}, 32'h00E12345);
    chk("hold_hit", {31'd0, rom_hit}, 32'd1);

    set_region(3'd1, 24'h008000, 24'h00F000, 24'h100000, 24'h000FFF, 4'hB);
    cfg_write(3'd3, 3'd0, 24'h008000);
    cfg_write(3'd3, 3'd1, 24'h008000);
    cfg_write(3'd3, 3'd2, 24'h300000);
    cfg_write(3'd3, 3'd3, 24'h000000);
    cfg_commit = 1'b1;
    cfg_write(3'd3, 3'd4, 24'h00000E);
    cfg_commit = 1'b0;
    chk("we_commit_busy", {31'd0, cfg_busy}, 32'd1);
    wait_idle("we_commit_done");
    lookup("prio", 24'h008123, 1'b1, 24'h100123, 3'd1, 3'b011);
    lookup("r3", 24'h00C000, 1'b1, 24'h300000, 3'd3, 3'b110);
    lookup("miss", 24'h7E0000, 1'b0, 24'h000000, 3'd0, 3'b000);

    snes_addr = 24'h412345;
    snes_addr_valid = 1'b1;
    cfg_commit = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        cfg_we = 1'b1;
        cfg_idx = 3'd0;
        cfg_field = 3'd2;
        cfg_data = 24'hA00000;
      end
      tick();
      cfg_commit = 1'b0;
      cfg_we = 1'b0;
      chk("b2b_busy", {31'd0, cfg_busy}, 32'd1);
      if (out_valid) chk("b2b_old", {8'd0, rom_addr}, 32'h00E12345);
    end
    snes_addr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("drain_busy", {31'd0, cfg_busy}, 32'd1);
      if (out_valid) chk("drain_old", {8'd0, rom_addr}, 32'h00E12345);
    end
    wait_idle("b2b_done");
    lookup("b2b_new", 24'h412345, 1'b1, 24'hA12345, 3'd0, 3'b111);

    snes_addr_valid = 1'b1;
    cfg_commit = 1'b1;
    tick();
    snes_addr_valid = 1'b0;
    cfg_commit = 1'b0;
    chk("pend_busy", {31'd0, cfg_busy}, 32'd1);
    RST_N = 1'b0;
    tick();
    chk("pend_rst_busy", {31'd0, cfg_busy}, 32'd0);
    chk("pend_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("pend_rst_addr", {8'd0, rom_addr}, 32'd0);
    RST_N = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, cfg_busy}, 32'd0);
    lookup("post_rst", 24'h412345, 1'b0, 24'h000000, 3'd0, 3'b000);

`ifdef REGION_MAPPER_HITCNT_EN
    set_region(3'd2, 24'h200000, 24'hF00000, 24'h000000, 24'h0FFFFF, 4'h8);
    commit();
    for (int i = 0; i < 3; i++) lookup("cnt", 24'h2ABCDE, 1'b1, 24'h0ABCDE, 3'd2, 3'b000);
    hit_cnt_idx = 3'd2;
    #1;
    chk("hitcnt2", {16'd0, hit_cnt}, 32'd3);
    hit_cnt_idx = 3'd0;
    #1;
    chk("hitcnt0", {16'd0, hit_cnt}, 32'd0);
    commit();
    hit_cnt_idx = 3'd2;
    #1;
    chk("hitcnt_clr", {16'd0, hit_cnt}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/region_mapper.md
REGION_MAPPER -- requirements
Module: region_mapper

Interface
REQ-001 SHALL have parameter NUM_REGIONS, default 8, meaning number of programmable map regions (2..16).
REQ-002 SHALL have parameter ADDR_W, default 24, meaning SNES and ROM address width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning hit-counter width.
REQ-004 SHALL have port CLK  input  1  system clock; the block uses one clock.
REQ-005 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port snes_addr  input  ADDR_W  requested SNES address.
REQ-007 SHALL have port snes_addr_valid  input  1  address lookup request.
REQ-008 SHALL have port cfg_we  input  1  shadow-table write strobe.
REQ-009 SHALL have port cfg_idx  input  IDX_W (clog2 NUM_REGIONS)  region being written.
REQ-010 SHALL have port cfg_field  input  3  field select: 0 match_val, 1 match_mask, 2 xlate_base, 3 xlate_mask, 4 flags[3:0] = {enable, writable, saveram, rom}.
REQ-011 SHALL have port cfg_data  input  ADDR_W  write data.
REQ-012 SHALL have port cfg_commit  input  1  request to copy shadow table to active table.
REQ-013 SHALL have port cfg_busy  output  1  commit pending.
REQ-014 SHALL have ports rom_addr (ADDR_W), rom_hit, is_rom, is_saveram, is_writable (1 each), region (IDX_W), out_valid (1), all outputs.
REQ-015 SHALL have ports hit_cnt_idx  input  IDX_W and hit_cnt  output  CNT_W; these exist only with REGION_MAPPER_HITCNT_EN.

Function
REQ-016 Region i SHALL match when enable=1 and (snes_addr & match_mask) == (match_val & match_mask).
REQ-017 The lookup SHALL be a 2-stage pipeline. Stage 1 registers the per-region match vector and the address. Stage 2 selects the lowest matching index and registers the outputs. out_valid SHALL follow snes_addr_valid with exactly 2 cycles of latency, at one lookup per cycle.
REQ-018 On a hit, rom_addr SHALL be xlate_base | (addr & xlate_mask), truncated to ADDR_W. rom_hit SHALL be 1 and the flags SHALL be copied from the winning region.
REQ-019 On a miss, rom_addr, rom_hit, the flags and region SHALL all be 0, with out_valid still asserted.
REQ-020 When out_valid=0, all outputs other than out_valid SHALL hold their previous values.
REQ-021 cfg_we SHALL write only the shadow table, taking effect the cycle after the strobe; the active table is unaffected.
REQ-022 Commit FSM states: IDLE, PEND, COPY.
- IDLE to PEND on cfg_commit.
- PEND to COPY on the first cycle in which snes_addr_valid=0 and both pipeline stages hold no valid lookup.
- COPY copies all regions in one cycle, then returns to IDLE.
REQ-023 cfg_busy SHALL be 1 in PEND and COPY.
REQ-024 cfg_commit while busy SHALL be ignored.
REQ-025 cfg_we during PEND SHALL update the shadow table, and that value SHALL be included in the copy.
REQ-026 Every lookup SHALL use a single consistent table, never a mix of old and new entries.
REQ-027 A simultaneous cfg_we and cfg_commit in IDLE SHALL include the written value in the commit.

Reset
REQ-028 With RST_N=0 at a CLK edge, the block SHALL clear both tables to all-zero, so every region is disabled.
REQ-029 During reset the FSM SHALL go to IDLE, the pipeline valids SHALL be cleared, all outputs SHALL be 0, and any pending commit SHALL be discarded.

Configuration
REQ-030 With REGION_MAPPER_HITCNT_EN defined, the block SHALL provide per-region CNT_W-bit saturating counters.
- A counter increments on each stage-2 hit of its region.
- Counters are cleared by reset and by COPY.
- hit_cnt SHALL give the count for region hit_cnt_idx combinationally.
REQ-031 Without REGION_MAPPER_HITCNT_EN, the counters and the hit_cnt_idx/hit_cnt ports SHALL be absent, and lookup behaviour SHALL be identical.

Structure
REQ-032 A shared package region_mapper_pkg SHALL hold:
- the field-select constants (FLD_MVAL, FLD_MMASK, FLD_XBASE, FLD_XMASK, FLD_FLAGS);
- the flag bit positions;
- the region entry struct;
- the FSM state enum.
REQ-033 The priority selection SHALL be a sub-module, region_prio_enc: NUM_REGIONS-bit vector in, lowest index plus any-hit out, purely combinational.

Verification
REQ-034 Region 0 set to val=0x400000, mask=0xF00000, xbase=0xE00000, xmask=0x01FFFF, flags=0xF, then committed. Lookup 0x412345 gives rom_addr=0xE12345, rom_hit=1 and region=0, two cycles later.
REQ-035 Region 1 matches 0x008000 and region 3 also matches it. The result SHALL be region=1 (lowest index wins).
REQ-036 Lookup 0x7E0000 with no matching region gives out_valid=1 with rom_hit=0 and rom_addr=0.
REQ-037 cfg_commit with back-to-back valid lookups for 10 cycles:
- cfg_busy stays 1 throughout;
- the old mapping applies until the first idle cycle;
- the new mapping applies after COPY.
REQ-038 RST_N=0 while in PEND gives cfg_busy=0 and all regions disabled; a subsequent lookup misses.
REQ-039 With REGION_MAPPER_HITCNT_EN, 3 hits on region 2 give hit_cnt=3 for hit_cnt_idx=2. When CNT_W=2, 5 hits give 3 (saturated).
